// File: rtl/boot_loader.sv
// Loads a big-endian length-prefixed byte image into instruction memory, then releases the CPU.
// Latency: 4 accepted bytes + 1 write cycle per word; cpu_rst 2 cycles after the last byte, run 3.
module boot_loader #(
    parameter int instr_size   = 32,
    parameter int addr_size    = 32,
    parameter int cell_numbers = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic                  start,
    output logic                  mem_we,
    output logic [addr_size-1:0]  mem_addr,
    output logic [instr_size-1:0] mem_data,
    output logic                  cpu_hold,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        RELEASE,
        RUN,
        ERROR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(cell_numbers);

    state_t                  state;
    state_t                  next_state;
    logic [15:0]             len;
    logic [15:0]             len_full;
    logic                    len_bad;
    logic [addr_size-1:0]    word_addr;
    logic [addr_size-1:0]    addr_next;
    logic [1:0]              byte_idx;
    logic [instr_size-1:0]   word;
    logic [instr_size-1:0]   word_shifted;
    logic                    accept;

    assign rx_ready     = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
    assign accept       = rx_valid && rx_ready;
    assign len_full     = {len[15:8], rx_data};
    assign len_bad      = (len_full == 16'd0) || (len_full[1:0] != 2'd0) ||
                          ({1'b0, len_full} > MAX_LEN);
    assign addr_next    = word_addr + addr_size'(4);
    assign word_shifted = {word[instr_size-9:0], rx_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LEN_HI;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LEN_HI:  if (accept) next_state = LEN_LO;
            LEN_LO:  if (accept) next_state = len_bad ? ERROR : DATA;
            DATA:    if (accept && byte_idx == 2'd3) next_state = WRITE;
            WRITE:   next_state = (addr_next == addr_size'(len)) ? RELEASE : DATA;
            RELEASE: next_state = RUN;
            RUN:     if (start) next_state = LEN_HI;
            ERROR:   if (start) next_state = LEN_HI;
            default: next_state = LEN_HI;
        endcase
    end

    // Status outputs are registered off the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            cpu_hold  <= 1'b1;
            cpu_rst   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            len       <= '0;
            word_addr <= '0;
            byte_idx  <= '0;
            word      <= '0;
        end else begin
            mem_we   <= (next_state == WRITE);
            cpu_rst  <= (next_state == RELEASE);
            done     <= (next_state == RUN);
            err      <= (next_state == ERROR);
            cpu_hold <= (next_state != RUN);
            case (state)
                LEN_HI: begin
                    if (accept) len[15:8] <= rx_data;
                end
                LEN_LO: begin
                    if (accept) begin
                        len[7:0]  <= rx_data;
                        word_addr <= '0;
                        byte_idx  <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        word     <= word_shifted;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_data <= word_shifted;
                            mem_addr <= word_addr;
                        end
                    end
                end
                WRITE: begin
                    word_addr <= addr_next;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Sequencer that fills the 32-bit instruction memory from a byte stream (UART receiver) and then releases the processor. While loading, it owns the memory write port and holds the program counter frozen. When the image is complete, it pulses a PC reset and hands control back to the CPU. It replaces file-based preloading on hardware and sits between the UART receiver and the instruction-fetch stage.

## Interface
- instr_size, 32, width of an instruction word and of mem_data
- addr_size, 32, width of mem_addr
- cell_numbers, 256, instruction memory capacity in bytes; upper bound on image length
- clk  in  1  global clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset; forces state LEN_HI immediately
- rx_valid  in  1  rx_data holds a received byte
- rx_data  in  8  received byte
- rx_ready  out  1  loader can accept a byte this cycle
- start  in  1  one-cycle request to reload; honoured only in RUN or ERROR
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  addr_size  byte address of the word being written
- mem_data  out  instr_size  word being written
- cpu_hold  out  1  freezes the PC (drives the fetch stage's hang input)
- cpu_rst  out  1  one-cycle PC reset pulse issued after loading
- done  out  1  image loaded, CPU running
- err  out  1  rejected image header

## Operation
- Image format: 2-byte big-endian length N in bytes, followed by N payload bytes.
- Payload bytes pack big-endian: the first byte of each group of 4 goes to [31:24], the last to [7:0].
- A byte is accepted when rx_valid && rx_ready. rx_ready is combinational from state and is 1 only in LEN_HI, LEN_LO and DATA.
- States and transitions:
  - LEN_HI: accepted byte goes to len[15:8]; go to LEN_LO.
  - LEN_LO: accepted byte goes to len[7:0]; clear the word address and byte index.
    - If N==0, N%4!=0, or N>cell_numbers: go to ERROR.
    - Otherwise go to DATA.
  - DATA: shift the byte into the word register and increment the byte index (mod 4). On the 4th byte, go to WRITE.
  - WRITE: mem_we=1, mem_addr=current word address, mem_data=assembled word. Then advance the address by 4. If the new address equals N, go to RELEASE; otherwise go to DATA.
  - RELEASE: cpu_rst=1 for exactly this cycle, with cpu_hold still 1; go to RUN.
  - RUN: cpu_hold=0, done=1. start → LEN_HI.
  - ERROR: err=1, cpu_hold=1. start → LEN_HI.
- On entering LEN_HI from start, clear done and err and raise cpu_hold.
- Arithmetic:
  - Length register is 16 bits.
  - Address counter is addr_size bits, compared against N zero-extended.
  - No wrap-around is possible because N ≤ cell_numbers.
- Bytes presented in WRITE, RELEASE, RUN or ERROR are not consumed (rx_ready=0). The upstream UART must hold or drop them.
- start is ignored in all loading states.
- rx_valid and start in the same RUN cycle: start wins and the byte is not consumed that cycle.

## Timing
- Reset values (asynchronous, take effect without a clock edge):
  - state LEN_HI, rx_ready=1, cpu_hold=1
  - mem_we=0, mem_addr=0, mem_data=0
  - cpu_rst=0, done=0, err=0
- All outputs other than rx_ready are registered.
- Per-word cost: 4 accepted bytes + 1 WRITE cycle. With rx_valid held high, one word is written every 5 cycles.
- mem_we is high for exactly 1 cycle per word. mem_addr and mem_data are stable in that cycle.
- Last-word latency: last byte accepted at edge k → WRITE in cycle k+1 → RELEASE (cpu_rst=1) in cycle k+2 → RUN (cpu_hold=0, done=1) from cycle k+3.
- Reset asserted mid-load:
  - The partial word is discarded and mem_we drops at once.
  - The next valid bytes are interpreted as a new header.
  - Memory contents already written are left untouched.

## Test plan
- Length 0x0008, bytes 11 22 33 44 55 66 77 88 streamed back-to-back → mem writes (0x0, 0x11223344) and (0x4, 0x55667788), each with a 1-cycle mem_we. cpu_rst pulses 1 cycle, then done=1, cpu_hold=0.
- Length 0x0006 → err=1, cpu_hold=1, no mem_we. A start pulse then returns rx_ready=1 and clears err.
- Length 0x0104 with cell_numbers=256 → ERROR. Length 0x0100 → 64 writes, final address 0xFC.
- rx_valid toggled every other cycle during the payload → the same words and addresses as the back-to-back case. rx_ready=0 in every WRITE cycle.
- rst asserted asynchronously after 6 payload bytes → outputs return to reset values before the next edge. A new 4-byte image then writes address 0x0.
- start in RUN followed by a new image → done falls in the cycle after start, cpu_hold=1 throughout reload, and memory is overwritten from 0x0.
